// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first two's-complement subtractor with start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out,
  output logic             bout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, bout_q, bout_d;
  logic             a_bit, b_bit, d, br_n, accept;

  assign a_bit  = a_q[0];
  assign b_bit  = b_q[0];
  assign d      = a_bit ^ b_bit ^ br_q;
  assign br_n   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  assign accept = start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    out_d   = out_q;
    bout_d  = bout_q;
    if (accept) begin
      state_d = RUN;
      a_d     = in0;
      b_d     = in1;
      cnt_d   = '0;
      br_d    = 1'b0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      res_d = {d, res_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
      br_d  = br_n;
      // Results publish only on the last bit so out never shows a partial word.
      if (cnt_q == LAST) begin
        state_d = DONE;
        out_d   = res_d;
        bout_d  = br_n;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      out_q   <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      out_q   <= out_d;
      bout_q  <= bout_d;
    end
  end

  assign out  = out_q;
  assign bout = bout_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [7:0] in0 = '0, in1 = '0, out;
  logic       bout, busy, done;
  int         tests = 0, fails = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in0(in0), .in1(in1),
    .out(out), .bout(bout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Pulses start with a/b, then waits (bounded) for done; cyc = busy cycles seen, -1 on timeout.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int cyc,
                        output logic [7:0] o, output logic bo, output logic chg);
    logic [7:0] prev;
    int n;
    @(negedge clk);
    in0 = a; in1 = b; start = 1'b1; prev = out;
    @(negedge clk);
    start = 1'b0; in0 = 8'($urandom); in1 = 8'($urandom);
    cyc = 0; chg = 1'b0; n = 0;
    while (!done && n < 20) begin
      if (busy) cyc++;
      if (out !== prev) chg = 1'b1;
      n++;
      @(negedge clk);
    end
    if (!done) cyc = -1;
    o = out; bo = bout;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    in0 = 8'($urandom); in1 = 8'($urandom);
    #1;
    tests++;
    if ({out, bout, busy, done} !== 11'b0) begin
      fails++; $display("FAIL reset_async: got %b expected 0", {out, bout, busy, done});
    end
    repeat (3) begin
      @(negedge clk); in0 = 8'($urandom); in1 = 8'($urandom); start = 1'($urandom);
    end
    start = 1'b0;
    tests++;
    if ({out, bout, busy, done} !== 11'b0) begin
      fails++; $display("FAIL reset_hold: got %b expected 0", {out, bout, busy, done});
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({out, bout, busy, done} !== 11'b0) begin
      fails++; $display("FAIL reset_release: got %b expected 0", {out, bout, busy, done});
    end
  endtask

  task automatic test_basic;
    int cyc; logic [7:0] o; logic bo, chg;
    run_op(8'h35, 8'h12, cyc, o, bo, chg);
    tests++;
    if (cyc !== 8) begin fails++; $display("FAIL basic_busy_cycles: got %0d expected 8", cyc); end
    tests++;
    if (o !== 8'h23) begin fails++; $display("FAIL basic_out: got %h expected 23", o); end
    tests++;
    if (bo !== 1'b0) begin fails++; $display("FAIL basic_bout: got %b expected 0", bo); end
    tests++;
    if (chg !== 1'b0) begin fails++; $display("FAIL basic_out_stable: out changed during RUN"); end
    @(negedge clk);
    tests++;
    if ({done, busy} !== 2'b00) begin
      fails++; $display("FAIL basic_done_pulse: got done,busy=%b expected 00", {done, busy});
    end
  endtask

  task automatic test_underflow;
    logic [7:0] ta [3] = '{8'h00, 8'hA5, 8'h80};
    logic [7:0] tb [3] = '{8'h01, 8'hA5, 8'hFF};
    logic [7:0] te [3] = '{8'hFF, 8'h00, 8'h81};
    logic       tbo [3] = '{1'b1, 1'b0, 1'b1};
    int cyc; logic [7:0] o; logic bo, chg;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], cyc, o, bo, chg);
      tests++;
      if (o !== te[i] || bo !== tbo[i] || cyc !== 8) begin
        fails++;
        $display("FAIL underflow_%0d: got out=%h bout=%b cyc=%0d expected out=%h bout=%b cyc=8",
                 i, o, bo, cyc, te[i], tbo[i]);
      end
    end
  endtask

  task automatic test_busy_protect;
    int n;
    @(negedge clk);
    in0 = 8'h10; in1 = 8'h01; start = 1'b1;
    @(negedge clk);
    in0 = 8'hFF; in1 = 8'h00;
    repeat (3) @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin n++; @(negedge clk); end
    tests++;
    if (!done || out !== 8'h0F || bout !== 1'b0) begin
      fails++; $display("FAIL busy_protect: got done=%b out=%h bout=%b expected done=1 out=0f bout=0",
                        done, out, bout);
    end
    n = 0;
    repeat (5) begin @(negedge clk); if (done || busy) n++; end
    tests++;
    if (n !== 0) begin fails++; $display("FAIL busy_no_second_done: %0d active cycles expected 0", n); end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    in0 = 8'h05; in1 = 8'h03; start = 1'b1;
    n = 0;
    @(negedge clk);
    while (!done && n < 20) begin n++; @(negedge clk); end
    tests++;
    if (!done || out !== 8'h02 || bout !== 1'b0) begin
      fails++; $display("FAIL b2b_first: got done=%b out=%h bout=%b expected done=1 out=02 bout=0",
                        done, out, bout);
    end
    in0 = 8'h03; in1 = 8'h05;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 20);
    start = 1'b0;
    tests++;
    if (n !== 9) begin fails++; $display("FAIL b2b_spacing: got %0d cycles expected 9", n); end
    tests++;
    if (!done || out !== 8'hFE || bout !== 1'b1) begin
      fails++; $display("FAIL b2b_second: got done=%b out=%h bout=%b expected done=1 out=fe bout=1",
                        done, out, bout);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, n; logic [7:0] o; logic bo, chg;
    @(negedge clk);
    in0 = 8'hF0; in1 = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({out, bout, busy, done} !== 11'b0) begin
      fails++; $display("FAIL reset_mid_outputs: got %b expected 0", {out, bout, busy, done});
    end
    @(negedge clk); rst = 1'b0;
    n = 0;
    repeat (12) begin @(negedge clk); if (done || busy) n++; end
    tests++;
    if (n !== 0) begin fails++; $display("FAIL reset_mid_no_done: %0d active cycles expected 0", n); end
    run_op(8'h09, 8'h04, cyc, o, bo, chg);
    tests++;
    if (o !== 8'h05 || bo !== 1'b0 || cyc !== 8) begin
      fails++; $display("FAIL reset_mid_recover: got out=%h bout=%b cyc=%0d expected out=05 bout=0 cyc=8",
                        o, bo, cyc);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_underflow;
    test_busy_protect;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor and the complement of the combinational full adder in the arithmetic set. It computes `in0 - in1` one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. The block has a start/busy/done handshake. It sits beside the adder family as the multi-cycle, area-minimal subtract path for later ALU work.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits (≥2).

Ports:
- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `rst`: input, 1 bit. Reset, asynchronous and active-high.
- `start`: input, 1 bit. Request to begin an operation. Sampled only when `busy`=0.
- `in0`: input, WIDTH bits. Minuend, captured on the accepting edge.
- `in1`: input, WIDTH bits. Subtrahend, captured on the accepting edge.
- `out`: output, WIDTH bits. Difference `(in0 - in1) mod 2^WIDTH`, registered.
- `bout`: output, 1 bit. Final borrow; 1 if and only if `in0 < in1` (unsigned).
- `busy`: output, 1 bit. Operation in progress.
- `done`: output, 1 bit. One-cycle pulse when `out`/`bout` become valid.

## Operation
- FSM has three states:
  - IDLE → RUN on `start`=1.
  - RUN → RUN while the bit counter is < WIDTH-1.
  - RUN → DONE on the bit where counter = WIDTH-1.
  - DONE → RUN if `start`=1; DONE → IDLE otherwise.
- Accept edge (`start`=1 in IDLE or DONE):
  - `in0` and `in1` load into shift registers A and B.
  - Bit counter clears to 0 and borrow register `br` clears to 0.
  - State becomes RUN.
- Each RUN edge performs one bit step:
  - `a=A[0]`, `b=B[0]`.
  - `d = a ^ b ^ br`.
  - `br_next = (~a & b) | (~(a ^ b) & br)`.
  - `d` shifts into a result register from the MSB side; A and B shift right; counter increments.
- Final RUN edge (counter = WIDTH-1):
  - `out` loads the complete result word, including this last `d`.
  - `bout` loads `br_next`.
  - State becomes DONE.
- Output behaviour:
  - `out` and `bout` hold their value until the next final RUN edge or reset. They do not change during RUN.
  - `busy` = (state == RUN). `done` = (state == DONE). Both are decoded from registered state, so they are glitch-free.
- Input behaviour:
  - `start` while `busy`=1 is ignored.
  - Changes on `in0`/`in1` after the accept edge have no effect.
- Arithmetic is unsigned modular. `bout` is the borrow, i.e. the inverted carry of `in0 + ~in1 + 1`.
- Reset (`rst`=1, at any time including mid-RUN):
  - Immediately forces state IDLE.
  - A, B, result, counter and `br` go to 0.
  - Outputs go to `out`=0, `bout`=0, `busy`=0, `done`=0.
  - No partial result is ever presented. After reset is released, the next operation is fully correct.

## Timing
- Accept edge E0. `busy` rises after E0 and stays high for exactly WIDTH cycles.
- The final RUN edge is E_WIDTH. After it, `done`=1 and `out`/`bout` are valid, for one cycle.
- Latency from accept edge to result valid: WIDTH edges (WIDTH=8: 8 cycles).
- Back-to-back throughput: one result per WIDTH+1 cycles when `start` is held high. The DONE cycle accepts the next operands.
- `start`=1 on edge E_WIDTH itself (still RUN) is ignored; only the DONE-cycle sample counts.
- Reset is asynchronous assert. Deassertion is assumed synchronous to `clk` by the system reset generator. The first edge after deassertion may accept `start`.

## Test plan
- Reset:
  - Assert `rst` with random inputs toggling → `out`=0, `bout`=0, `busy`=0, `done`=0 immediately, without waiting for a clock.
  - Release `rst` with `start`=0 → all outputs stay 0.
- Basic subtract (WIDTH=8):
  - `in0`=0x35, `in1`=0x12, pulse `start` one cycle → `busy` high 8 cycles.
  - Then `done` pulses once with `out`=0x23 and `bout`=0.
  - `out` unchanged during RUN.
- Underflow and equal operands:
  - 0x00−0x01 → `out`=0xFF, `bout`=1.
  - 0xA5−0xA5 → `out`=0x00, `bout`=0.
  - 0x80−0xFF → `out`=0x81, `bout`=1.
- Busy protection:
  - Start 0x10−0x01, then during RUN drive `start`=1 with `in0`=0xFF and `in1`=0x00 for 3 cycles → result is 0x0F with `bout`=0.
  - No second `done` unless `start` is still high in the DONE cycle.
- Back-to-back:
  - Hold `start`=1 with 0x05−0x03, then present 0x03−0x05 in the DONE cycle.
  - Response: first `done` gives 0x02 with `bout`=0; the second `done`, exactly 9 cycles later, gives 0xFE with `bout`=1.
- Reset mid-operation:
  - Start 0xF0−0x0F, assert `rst` after 4 RUN cycles → outputs 0 immediately, and no `done` follows.
  - Then start 0x09−0x04 → `out`=0x05, `bout`=0 after 8 cycles.
